// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: shares one register-file read port between operands A and B.
// Optional writeback forwarding into the captured operands is enabled with OPFETCH_FWD_EN.
module operand_fetch_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [AW-1:0] issue_src_a,
  input  logic [AW-1:0] issue_src_b,
  input  logic          issue_use_b,
  output logic          rf_rd_en,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [DW-1:0] rf_rd_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] opa_data,
  output logic [DW-1:0] opb_data,
  output logic          op_valid,
  input  logic          op_ready
);

  typedef enum logic [2:0] {IDLE, READ_A, CAP_A, CAP_B, OUT} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   src_a_reg, src_a_next;
  logic [AW-1:0]   src_b_reg, src_b_next;
  logic            use_b_reg, use_b_next;
  logic            issue_ready_reg, issue_ready_next;
  logic            rf_rd_en_reg, rf_rd_en_next;
  logic [AW-1:0]   rf_rd_addr_reg, rf_rd_addr_next;
  logic [DW-1:0]   opa_reg, opa_next;
  logic [DW-1:0]   opb_reg, opb_next;
  logic            op_valid_reg, op_valid_next;
  logic [DW-1:0]   cap_a_data, cap_b_data;

`ifdef OPFETCH_FWD_EN
  // A writeback landing in the capture cycle is newer than what the RF returned.
  assign cap_a_data = (wb_en && (wb_addr == src_a_reg)) ? wb_data : rf_rd_data;
  assign cap_b_data = (wb_en && (wb_addr == src_b_reg)) ? wb_data : rf_rd_data;
`else
  logic wb_unused;
  assign wb_unused  = ^{wb_en, wb_addr, wb_data};
  assign cap_a_data = rf_rd_data;
  assign cap_b_data = rf_rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      src_a_reg       <= '0;
      src_b_reg       <= '0;
      use_b_reg       <= 1'b0;
      issue_ready_reg <= 1'b0;
      rf_rd_en_reg    <= 1'b0;
      rf_rd_addr_reg  <= '0;
      opa_reg         <= '0;
      opb_reg         <= '0;
      op_valid_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      src_a_reg       <= src_a_next;
      src_b_reg       <= src_b_next;
      use_b_reg       <= use_b_next;
      issue_ready_reg <= issue_ready_next;
      rf_rd_en_reg    <= rf_rd_en_next;
      rf_rd_addr_reg  <= rf_rd_addr_next;
      opa_reg         <= opa_next;
      opb_reg         <= opb_next;
      op_valid_reg    <= op_valid_next;
    end
  end

  // Outputs are computed for the state being entered so every port is a flop.
  always_comb begin
    state_next      = state_reg;
    src_a_next      = src_a_reg;
    src_b_next      = src_b_reg;
    use_b_next      = use_b_reg;
    rf_rd_en_next   = 1'b0;
    rf_rd_addr_next = rf_rd_addr_reg;
    opa_next        = opa_reg;
    opb_next        = opb_reg;
    op_valid_next   = op_valid_reg;
    case (state_reg)
      IDLE: begin
        if (issue_valid && issue_ready_reg) begin
          src_a_next      = issue_src_a;
          src_b_next      = issue_src_b;
          use_b_next      = issue_use_b;
          rf_rd_en_next   = 1'b1;
          rf_rd_addr_next = issue_src_a;
          state_next      = READ_A;
        end
      end
      READ_A: begin
        state_next = CAP_A;
        if (use_b_reg) begin
          rf_rd_en_next   = 1'b1;
          rf_rd_addr_next = src_b_reg;
        end
      end
      CAP_A: begin
        opa_next = cap_a_data;
        if (use_b_reg) begin
          state_next = CAP_B;
        end else begin
          opb_next      = '0;
          op_valid_next = 1'b1;
          state_next    = OUT;
        end
      end
      CAP_B: begin
        opb_next      = cap_b_data;
        op_valid_next = 1'b1;
        state_next    = OUT;
      end
      OUT: begin
        if (op_ready) begin
          op_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    issue_ready_next = (state_next == IDLE);
  end

  assign issue_ready = issue_ready_reg;
  assign rf_rd_en    = rf_rd_en_reg;
  assign rf_rd_addr  = rf_rd_addr_reg;
  assign opa_data    = opa_reg;
  assign opb_data    = opb_reg;
  assign op_valid    = op_valid_reg;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed and randomized bench for operand_fetch_ctrl with a register-file model
// and a transaction-level reference (operand values, read count, latency).
module tb_operand_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_src_a, issue_src_b;
  logic        issue_use_b;
  logic        rf_rd_en;
  logic [3:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] opa_data, opb_data;
  logic        op_valid;
  logic        op_ready;

`ifdef OPFETCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int rd_count = 0;
  logic [15:0] rf_mem [16];

  operand_fetch_ctrl #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_use_b(issue_use_b),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .opa_data(opa_data), .opb_data(opb_data),
    .op_valid(op_valid), .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  // Register file: data returns the cycle after the read strobe.
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
    if (rst_n && rf_rd_en) rd_count <= rd_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (issue_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("issue_ready_timeout", {31'd0, issue_ready}, 32'd1);
  endtask

  // One complete fetch: accept, read sequence, latency, operand values, hold, release.
  task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input bit ub,
                        input int hold, input bit rdy_early, input bit fwd);
    logic [15:0] ea, eb;
    int rc0;
    ea = (fwd && FWD) ? 16'hBEEF : rf_mem[a];
    eb = ub ? rf_mem[b] : 16'h0000;
    wait_idle();
    issue_valid = 1'b1; issue_src_a = a; issue_src_b = b; issue_use_b = ub;
    op_ready = rdy_early;
    rc0 = rd_count;
    tick();                                  // E0
    issue_valid = 1'($urandom_range(0, 1));
    issue_src_a = 4'($urandom); issue_src_b = 4'($urandom); issue_use_b = 1'($urandom);
    check("busy_issue_ready", {31'd0, issue_ready}, 32'd0);
    check("rd_en_a", {31'd0, rf_rd_en}, 32'd1);
    check("rd_addr_a", {28'd0, rf_rd_addr}, {28'd0, a});
    check("op_valid_early1", {31'd0, op_valid}, 32'd0);
    tick();                                  // E0+1
    if (fwd) begin wb_en = 1'b1; wb_addr = a; wb_data = 16'hBEEF; end
    check("rd_en_b", {31'd0, rf_rd_en}, {31'd0, ub});
    if (ub) check("rd_addr_b", {28'd0, rf_rd_addr}, {28'd0, b});
    check("op_valid_early2", {31'd0, op_valid}, 32'd0);
    tick();                                  // E0+2
    wb_en = 1'b0;
    if (ub) begin
      check("op_valid_early3", {31'd0, op_valid}, 32'd0);
      check("rd_en_capb", {31'd0, rf_rd_en}, 32'd0);
      tick();                                // E0+3
    end
    check("op_valid_latency", {31'd0, op_valid}, 32'd1);
    check("opa", {16'd0, opa_data}, {16'd0, ea});
    check("opb", {16'd0, opb_data}, {16'd0, eb});
    check("rf_reads", rd_count - rc0, ub ? 32'd2 : 32'd1);
    for (int i = 0; i < hold; i++) begin
      op_ready = 1'b0;
      issue_valid = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", {31'd0, op_valid}, 32'd1);
      check("hold_opa", {16'd0, opa_data}, {16'd0, ea});
      check("hold_opb", {16'd0, opb_data}, {16'd0, eb});
      check("hold_issue_ready", {31'd0, issue_ready}, 32'd0);
      check("hold_rd_en", {31'd0, rf_rd_en}, 32'd0);
    end
    op_ready = 1'b1;
    issue_valid = 1'b0;
    tick();
    check("release_valid", {31'd0, op_valid}, 32'd0);
    check("release_ready", {31'd0, issue_ready}, 32'd1);
    check("addr_holds", {28'd0, rf_rd_addr}, {28'd0, (ub ? b : a)});
    if (!rdy_early) op_ready = 1'b0;
    $display("txn a=%0d b=%0d use_b=%0d hold=%0d fwd=%0d opa=%h opb=%h", a, b, ub, hold, fwd, opa_data, opb_data);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_issue_ready"}, {31'd0, issue_ready}, 32'd0);
    check({tag, "_rd_en"}, {31'd0, rf_rd_en}, 32'd0);
    check({tag, "_rd_addr"}, {28'd0, rf_rd_addr}, 32'd0);
    check({tag, "_opa"}, {16'd0, opa_data}, 32'd0);
    check({tag, "_opb"}, {16'd0, opb_data}, 32'd0);
    check({tag, "_op_valid"}, {31'd0, op_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'($urandom);
    rf_mem[3] = 16'h1234; rf_mem[5] = 16'hABCD; rf_mem[7] = 16'h00FF;
    rst_n = 1'b0; issue_valid = 1'b0; issue_src_a = '0; issue_src_b = '0; issue_use_b = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    check("ready_before_edge", {31'd0, issue_ready}, 32'd0);
    tick();
    check("ready_after_release", {31'd0, issue_ready}, 32'd1);

    do_txn(4'd3, 4'd5, 1'b1, 0, 1'b0, 1'b0);   // two-operand
    do_txn(4'd7, 4'd0, 1'b0, 0, 1'b0, 1'b0);   // one-operand
    do_txn(4'd3, 4'd5, 1'b1, 5, 1'b0, 1'b0);   // backpressure
    do_txn(4'd3, 4'd5, 1'b1, 0, 1'b0, 1'b1);   // writeback during CAP_A
    op_ready = 1'b1;                            // back-to-back with op_ready tied high
    do_txn(4'd1, 4'd2, 1'b1, 0, 1'b1, 1'b0);
    do_txn(4'd7, 4'd7, 1'b1, 0, 1'b1, 1'b0);
    do_txn(4'd4, 4'd9, 1'b0, 0, 1'b1, 1'b0);
    op_ready = 1'b0;

    // Reset in the middle of CAP_B.
    wait_idle();
    issue_valid = 1'b1; issue_src_a = 4'd3; issue_src_b = 4'd5; issue_use_b = 1'b1;
    tick(); issue_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    check_all_zero("midreset_hold");
    rst_n = 1'b1;
    tick();
    check("midreset_ready", {31'd0, issue_ready}, 32'd1);
    check("midreset_valid", {31'd0, op_valid}, 32'd0);
    $display("txn reset during CAP_B");

    for (int n = 0; n < 20; n++) begin
      do_txn(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'b0);
      op_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
